iomem_arbiter: RTL and testbench
================================

Name: iomem_arbiter

Overview:
- Two-master, one-slave arbiter for the PicoSoC iomem bus (native picorv32 valid/ready protocol).
- Master 0 is the SoC CPU iomem port. Master 1 is a secondary requester, e.g. a UART debug bridge or a DMA.
- The slave port feeds the board-level iomem decode: GPIO/LED register at 0x03xx_xxxx and future peripherals.
- Provides round-robin fairness and a bus timeout, so a non-responding peripheral cannot hang a master.

Parameters:
- TIMEOUT, 255, cycles the slave may take before the arbiter forces completion; legal range 1..65535.
- ERR_RDATA, 32'hDEAD_BEEF, read data returned to the master on a timeout completion.

Ports:
- clk  in  1  system clock; all state on posedge
- reset  in  1  asynchronous, active-high reset
- m0_valid  in  1  master 0 request; held until m0_ready
- m0_ready  out  1  master 0 completion pulse (one cycle)
- m0_wstrb  in  4  byte write strobes; 0 = read
- m0_addr  in  32  master 0 address
- m0_wdata  in  32  master 0 write data
- m0_rdata  out  32  master 0 read data; valid when m0_ready
- m1_valid, m1_ready, m1_wstrb, m1_addr, m1_wdata, m1_rdata: identical set for master 1
- s_valid  out  1  slave request
- s_ready  in  1  slave completion
- s_wstrb  out  4  forwarded strobes
- s_addr  out  32  forwarded address
- s_wdata  out  32  forwarded write data
- s_rdata  in  32  slave read data
- grant  out  2  one-hot current owner; 00 = idle
- timeout_err  out  1  sticky; set by any timeout completion
- err_clear  in  1  synchronous clear of timeout_err

Behaviour:
- States: IDLE, OWN0, OWN1. The state register and last-owner register `last` are reset asynchronously.
- Reset values:
  - state = IDLE, last = 1 (so m0 wins the first tie), timeout counter = 0, timeout_err = 0.
  - All outputs are 0, including s_valid, m*_ready, m*_rdata and grant.
- IDLE transitions:
  - Only m0_valid -> OWN0.
  - Only m1_valid -> OWN1.
  - Both -> the master that is not `last`.
  - None -> stay in IDLE.
  - Grant takes effect the cycle after valid is first seen: one cycle of arbitration latency.
- OWNx datapath:
  - s_valid = mx_valid (combinational from registered state).
  - s_wstrb, s_addr and s_wdata mux from master x.
  - When not owned, s_* are driven 0.
- Normal completion (OWNx and s_ready):
  - mx_ready = 1 and mx_rdata = s_rdata, combinationally in the same cycle.
  - Next state = IDLE, last = x.
  - s_valid is therefore low in the following cycle.
  - Back-to-back requests from the same master are granted again one cycle later, unless the other master is waiting.
- Timeout counter:
  - Counts cycles spent in OWNx.
  - Clears on entering IDLE.
  - Saturates; it never wraps.
- Timeout completion (OWNx, counter == TIMEOUT-1, s_ready low):
  - mx_ready = 1, mx_rdata = ERR_RDATA, s_valid forced 0 in that cycle.
  - timeout_err set; next state = IDLE, last = x.
  - Writes that time out are dropped silently apart from timeout_err.
- s_ready and timeout in the same cycle: the slave wins; normal completion, no error.
- Master drops valid while owning (protocol violation): return to IDLE next cycle, no ready, no error, last unchanged.
- s_ready in IDLE: ignored.
- The non-owning master never sees ready; its mx_rdata is 0.
- err_clear and a timeout completion in the same cycle: timeout_err stays set (set wins).
- Reset asserted mid-transaction: all outputs drop to 0 immediately (asynchronous). The pending transaction is abandoned; masters reissue after reset.

Decomposition:
- Package iomem_pkg: state encoding (IDLE/OWN0/OWN1), default ERR_RDATA, bus width constants (ADDR_W=32, DATA_W=32, STRB_W=4).
- One natural sub-module: iomem_rr_pick, a combinational 2-way round-robin chooser taking valids and `last`, returning one-hot grant.
- The timeout counter and muxes stay in the top.

Test Plan:
- m0 read, slave s_ready 3 cycles after s_valid, s_rdata=0x0000_00A5 -> m0_ready pulses once with m0_rdata=0x0000_00A5; grant=01 during the transaction; s_valid low the next cycle.
- m0 and m1 assert together, each with repeated reads, slave ready in 1 cycle -> grants alternate 01,10,01,10 starting with m0; no master starves.
- m1 write wstrb=4'b0011, wdata=0x1234_5678 to 0x0300_0000 -> slave sees the identical strobe/addr/data; m1_ready after s_ready; m0_ready stays 0.
- Slave never responds, TIMEOUT=255 -> m0_ready exactly 255 cycles after the grant with m0_rdata=0xDEAD_BEEF, timeout_err=1; err_clear -> 0 the next cycle.
- s_ready arrives in the same cycle the counter hits TIMEOUT-1 -> normal data returned, timeout_err stays 0.
- reset pulsed while OWN1 is mid-transaction -> s_valid, m1_ready and grant go 0 without a clock edge; after release, simultaneous requests grant m0 first.

Source files
------------

// File: rtl/iomem_pkg.sv
// Shared types and constants for the PicoSoC iomem arbiter.
// Bus widths, FSM encoding and the default timeout read data.
package iomem_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int CNT_W  = 16;

  localparam logic [DATA_W-1:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;
endpackage

// File: rtl/iomem_if.sv
// picorv32 native valid/ready memory bus.
// The requester drives valid/wstrb/addr/wdata; the responder drives ready/rdata.
interface iomem_if;
  import iomem_pkg::*;

  logic              valid;
  logic              ready;
  logic [STRB_W-1:0] wstrb;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (
    output valid, wstrb, addr, wdata,
    input  ready, rdata
  );

  modport slave (
    input  valid, wstrb, addr, wdata,
    output ready, rdata
  );
endinterface

// File: rtl/iomem_rr_pick.sv
// Two-way round-robin chooser: on a tie the master that was not
// served last wins; a lone request always wins.
module iomem_rr_pick (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] pick
);
  always_comb begin
    pick = 2'b00;
    unique case (1'b1)
      (valid == 2'b11): pick = last ? 2'b01 : 2'b10;
      (valid == 2'b01): pick = 2'b01;
      (valid == 2'b10): pick = 2'b10;
      default:          pick = 2'b00;
    endcase
  end
endmodule

// File: rtl/iomem_arbiter.sv
// Two-master, one-slave iomem arbiter with round-robin fairness
// and a per-transaction timeout that forces an error completion.
module iomem_arbiter
  import iomem_pkg::*;
#(
  parameter int unsigned       TIMEOUT   = 255,
  parameter logic [DATA_W-1:0] ERR_RDATA = ERR_RDATA_DEF
) (
  input  logic       clk,
  input  logic       reset,
  iomem_if.slave     m0,
  iomem_if.slave     m1,
  iomem_if.master    s,
  output logic [1:0] grant,
  output logic       timeout_err,
  input  logic       err_clear
);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  state_t           state;
  state_t           state_nx;
  logic             last;
  logic             last_nx;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       pick;
  logic             own_v;
  logic             done_ok;
  logic             done_to;

  iomem_rr_pick u_pick (
    .valid ({m1.valid, m0.valid}),
    .last  (last),
    .pick  (pick)
  );

  always_comb begin
    own_v = 1'b0;
    unique case (state)
      OWN0:    own_v = m0.valid;
      OWN1:    own_v = m1.valid;
      default: own_v = 1'b0;
    endcase
  end

  // The slave wins a tie with the timeout.
  assign done_ok = own_v & s.ready;
  assign done_to = own_v & ~s.ready & (cnt == LIMIT);

  always_comb begin
    state_nx = state;
    last_nx  = last;
    grant    = 2'b00;
    s.valid  = 1'b0;
    s.wstrb  = '0;
    s.addr   = '0;
    s.wdata  = '0;
    m0.ready = 1'b0;
    m0.rdata = '0;
    m1.ready = 1'b0;
    m1.rdata = '0;
    unique case (state)
      IDLE: begin
        if (pick[0])      state_nx = OWN0;
        else if (pick[1]) state_nx = OWN1;
      end
      OWN0: begin
        grant    = 2'b01;
        s.valid  = m0.valid & ~done_to;
        s.wstrb  = m0.wstrb;
        s.addr   = m0.addr;
        s.wdata  = m0.wdata;
        m0.ready = done_ok | done_to;
        if (done_ok)      m0.rdata = s.rdata;
        else if (done_to) m0.rdata = ERR_RDATA;
        if (!m0.valid || done_ok || done_to) state_nx = IDLE;
        if (done_ok || done_to) last_nx = 1'b0;
      end
      OWN1: begin
        grant    = 2'b10;
        s.valid  = m1.valid & ~done_to;
        s.wstrb  = m1.wstrb;
        s.addr   = m1.addr;
        s.wdata  = m1.wdata;
        m1.ready = done_ok | done_to;
        if (done_ok)      m1.rdata = s.rdata;
        else if (done_to) m1.rdata = ERR_RDATA;
        if (!m1.valid || done_ok || done_to) state_nx = IDLE;
        if (done_ok || done_to) last_nx = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last        <= 1'b1;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nx;
      last  <= last_nx;
      if (state == IDLE || state_nx == IDLE) cnt <= '0;
      else if (cnt != '1)                    cnt <= cnt + 1'b1;
      if (done_to)        timeout_err <= 1'b1;
      else if (err_clear) timeout_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_iomem_arbiter.sv
// Bench for iomem_arbiter: reset, vector table, directed corner
// sequences and a random phase against a transaction-level model.
module tb_iomem_arbiter;
  import iomem_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       err_clear = 1'b0;
  logic [1:0] grant;
  logic       timeout_err;

  iomem_if m0i ();
  iomem_if m1i ();
  iomem_if si ();

  int total = 0;
  int passed = 0;

  iomem_arbiter #(
    .TIMEOUT   (255),
    .ERR_RDATA (32'hDEAD_BEEF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .m0          (m0i),
    .m1          (m1i),
    .s           (si),
    .grant       (grant),
    .timeout_err (timeout_err),
    .err_clear   (err_clear)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic       v0, v1, sr;
    logic [1:0] g;
    logic       r0, r1, sv;
  } vec_t;

  localparam logic [31:0] A0 = 32'h0300_0010;
  localparam logic [31:0] A1 = 32'h0300_0020;

  vec_t        tbl [15];
  int          owned;
  bit          seen;
  logic [31:0] c_rd;
  logic        c_sv;

  // random-phase model state
  bit          act [2];
  logic [31:0] ra [2];
  logic [31:0] rd [2];
  logic [3:0]  rs [2];
  bit          busy;
  int          owner;
  int          mlast;
  logic        sr;
  logic [31:0] srd;
  logic [1:0]  eg;
  logic        esv, er0, er1;
  logic [3:0]  ews;
  logic [31:0] ea, ed, erd0, erd1, mk0, mk1;

  task automatic chk(input string name, input logic [159:0] act_v,
                     input logic [159:0] exp_v);
    total++;
    if (act_v !== exp_v)
      $display("FAIL %s: got %0h expected %0h", name, act_v, exp_v);
    else
      passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    m0i.valid = 0; m0i.wstrb = 0; m0i.addr = 0; m0i.wdata = 0;
    m1i.valid = 0; m1i.wstrb = 0; m1i.addr = 0; m1i.wdata = 0;
    si.ready = 0; si.rdata = 0; err_clear = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    idle_in();
    repeat (2) @(posedge clk);
    #1 reset = 0;
  endtask

  function automatic logic [159:0] outs();
    return {grant, timeout_err, si.valid, si.wstrb, si.addr, si.wdata,
            m0i.ready, m0i.rdata, m1i.ready, m1i.rdata};
  endfunction

  function automatic vec_t mk(input logic [2:0] in, input logic [1:0] g,
                              input logic [2:0] o);
    vec_t v;
    v.v0 = in[2]; v.v1 = in[1]; v.sr = in[0];
    v.g  = g;
    v.r0 = o[2];  v.r1 = o[1];  v.sv = o[0];
    return v;
  endfunction

  initial begin
    // inputs {v0,v1,s_ready}, grant, {r0,r1,s_valid}
    tbl[0]  = mk(3'b111, 2'b00, 3'b000);
    tbl[1]  = mk(3'b111, 2'b01, 3'b101);
    tbl[2]  = mk(3'b111, 2'b00, 3'b000);
    tbl[3]  = mk(3'b111, 2'b10, 3'b011);
    tbl[4]  = mk(3'b111, 2'b00, 3'b000);
    tbl[5]  = mk(3'b111, 2'b01, 3'b101);
    tbl[6]  = mk(3'b110, 2'b00, 3'b000);
    tbl[7]  = mk(3'b110, 2'b10, 3'b001);
    tbl[8]  = mk(3'b111, 2'b10, 3'b011);
    tbl[9]  = mk(3'b100, 2'b00, 3'b000);
    tbl[10] = mk(3'b100, 2'b01, 3'b001);
    tbl[11] = mk(3'b000, 2'b01, 3'b000);
    tbl[12] = mk(3'b110, 2'b00, 3'b000);
    tbl[13] = mk(3'b111, 2'b01, 3'b101);
    tbl[14] = mk(3'b000, 2'b00, 3'b000);

    // reset state with busy inputs
    idle_in();
    m0i.valid = 1; m1i.valid = 1; si.ready = 1; si.rdata = '1;
    @(negedge clk);
    chk("reset_outs", outs(), '0);

    // vector table
    do_reset();
    m0i.addr = A0; m1i.addr = A1;
    for (int i = 0; i < 15; i++) begin
      m0i.valid = tbl[i].v0; m1i.valid = tbl[i].v1;
      si.ready = tbl[i].sr; si.rdata = 32'hA000_0000 + i;
      @(negedge clk);
      ea = (tbl[i].g == 2'b01) ? A0 : (tbl[i].g == 2'b10) ? A1 : '0;
      chk($sformatf("tbl%0d", i),
          {grant, m0i.ready, m1i.ready, si.valid, si.addr},
          {tbl[i].g, tbl[i].r0, tbl[i].r1, tbl[i].sv, ea});
      if (tbl[i].r0 || tbl[i].r1)
        chk($sformatf("tbl%0d_rdata", i), {m0i.rdata, m1i.rdata},
            {tbl[i].r0 ? 32'hA000_0000 + i : 32'h0,
             tbl[i].r1 ? 32'hA000_0000 + i : 32'h0});
      tick();
    end

    // A: m0 read, slave ready three cycles after s_valid
    do_reset();
    m0i.valid = 1; m0i.addr = 32'h0300_0000;
    @(negedge clk);
    chk("A_idle", {grant, si.valid}, 3'b000);
    tick();
    @(negedge clk);
    chk("A_grant", {grant, si.valid, m0i.ready}, 4'b0110);
    for (int i = 0; i < 2; i++) begin
      tick();
      @(negedge clk);
      chk("A_wait", {grant, m0i.ready}, 3'b010);
    end
    tick();
    si.ready = 1; si.rdata = 32'h0000_00A5;
    @(negedge clk);
    chk("A_done", {grant, m0i.ready, m0i.rdata, m1i.ready},
        {2'b01, 1'b1, 32'h0000_00A5, 1'b0});
    tick();
    si.ready = 0; m0i.valid = 0;
    @(negedge clk);
    chk("A_after", {si.valid, m0i.ready}, 2'b00);

    // B: m1 write forwarded unchanged
    tick();
    m1i.valid = 1; m1i.wstrb = 4'b0011;
    m1i.addr = 32'h0300_0000; m1i.wdata = 32'h1234_5678; si.ready = 1;
    @(negedge clk);
    chk("B_idle", {grant, m1i.ready}, 3'b000);
    tick();
    @(negedge clk);
    chk("B_bus", {si.valid, si.wstrb, si.addr, si.wdata},
        {1'b1, 4'b0011, 32'h0300_0000, 32'h1234_5678});
    chk("B_ready", {grant, m1i.ready, m0i.ready}, 4'b1010);
    tick();
    idle_in();

    // C: timeout, with err_clear held so set-wins is exercised
    m0i.valid = 1; m0i.addr = 32'h0300_0100; err_clear = 1;
    owned = 0; seen = 0; c_rd = '0; c_sv = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (grant == 2'b01) owned++;
      if (m0i.ready) begin
        seen = 1; c_rd = m0i.rdata; c_sv = si.valid;
        break;
      end
      tick();
    end
    chk("C_seen", 160'(seen), 160'(1));
    chk("C_cycle", 160'(owned), 160'(255));
    chk("C_rdata", {c_sv, c_rd}, {1'b0, 32'hDEAD_BEEF});
    tick();
    m0i.valid = 0;
    @(negedge clk);
    chk("C_set_wins", 160'(timeout_err), 160'(1));
    tick();
    @(negedge clk);
    chk("C_clear", 160'(timeout_err), 160'(0));
    err_clear = 0;

    // D: s_ready in the very cycle the timeout would fire
    tick();
    m0i.valid = 1; si.rdata = 32'h5A5A_0001;
    owned = 0; seen = 0; c_rd = '0;
    for (int i = 0; i < 400; i++) begin
      si.ready = (owned == 254);
      @(negedge clk);
      if (grant == 2'b01) owned++;
      if (m0i.ready) begin
        seen = 1; c_rd = m0i.rdata;
        break;
      end
      tick();
    end
    chk("D_cycle", {seen, 32'(owned)}, {1'b1, 32'd255});
    chk("D_rdata", 160'(c_rd), 160'(32'h5A5A_0001));
    tick();
    m0i.valid = 0; si.ready = 0;
    @(negedge clk);
    chk("D_no_err", 160'(timeout_err), 160'(0));

    // E: asynchronous reset during an OWN1 transaction
    tick();
    m1i.valid = 1; m1i.addr = A1;
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("E_own1", {grant, si.valid}, 3'b101);
    si.ready = 1;
    #1;
    chk("E_pre", 160'(m1i.ready), 160'(1));
    #1 reset = 1;
    #1;
    chk("E_async", {si.valid, m1i.ready, grant}, 4'b0000);
    si.ready = 0; m1i.valid = 0;
    @(posedge clk);
    #1 reset = 0;
    m0i.valid = 1; m1i.valid = 1;
    @(negedge clk);
    chk("E_idle", 160'(grant), 160'(0));
    tick();
    @(negedge clk);
    chk("E_m0_first", 160'(grant), 160'(2'b01));

    // random phase against a transaction-level model
    do_reset();
    busy = 0; owner = 0; mlast = 1;
    act[0] = 0; act[1] = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 2; i++)
        if (!act[i] && $urandom_range(0, 2) == 0) begin
          act[i] = 1;
          ra[i] = 32'h0300_0000 | (32'($urandom_range(0, 15)) << 2);
          rs[i] = $urandom_range(0, 1) ? 4'h0 : 4'($urandom);
          rd[i] = $urandom;
        end
      m0i.valid = act[0]; m0i.addr = ra[0]; m0i.wstrb = rs[0]; m0i.wdata = rd[0];
      m1i.valid = act[1]; m1i.addr = ra[1]; m1i.wstrb = rs[1]; m1i.wdata = rd[1];
      sr = 1'($urandom_range(0, 1)); srd = $urandom;
      si.ready = sr; si.rdata = srd;
      @(negedge clk);
      eg = 0; esv = 0; ews = 0; ea = 0; ed = 0; er0 = 0; er1 = 0;
      erd0 = 0; erd1 = 0; mk0 = '1; mk1 = '1;
      if (busy) begin
        eg = (owner == 1) ? 2'b10 : 2'b01;
        esv = 1; ews = rs[owner]; ea = ra[owner]; ed = rd[owner];
        if (owner == 0) begin
          er0 = sr;
          if (sr) erd0 = srd; else mk0 = '0;
        end else begin
          er1 = sr;
          if (sr) erd1 = srd; else mk1 = '0;
        end
      end
      chk("rand_bus",
          {grant, si.valid, si.wstrb, si.addr, si.wdata, m0i.ready, m1i.ready},
          {eg, esv, ews, ea, ed, er0, er1});
      chk("rand_rdata", {m0i.rdata & mk0, m1i.rdata & mk1}, {erd0, erd1});
      if (busy) begin
        if (sr) begin
          act[owner] = 0; busy = 0; mlast = owner;
        end
      end else if (act[0] || act[1]) begin
        if (act[0] && act[1]) owner = (mlast == 0) ? 1 : 0;
        else                  owner = act[1] ? 1 : 0;
        busy = 1;
      end
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
